fifo_wr_ctrl: RTL and testbench

Write-side controller for the asynchronous FIFO. It sits directly upstream of the dual-port RAM in the `wclk` domain and drives the RAM write-enable and write address. It maintains the binary and Gray write pointers and exports the Gray pointer to the read domain. It also synchronises the read domain's Gray pointer and produces full, almost-full, fill-level and sticky overflow flags.

---
 rtl/fifo_wr_ctrl.sv | 76 +++++++
 tb/tb_fifo_wr_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: async FIFO write-side pointer, full/level flags and RAM write port
module fifo_wr_ctrl #(
    parameter int ADDR_W   = 3,
    parameter int AFULL_TH = 6
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              winc,
    input  logic [ADDR_W:0]   rptr_gray_async,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              wfull,
    output logic              walmost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              woverflow
);
    localparam logic [ADDR_W:0] AFULL_LV = (ADDR_W+1)'(AFULL_TH);

    logic [ADDR_W:0] wbin_q, wbin_d;
    logic [ADDR_W:0] wgray_q, wgray_d;
    logic [ADDR_W:0] rq1_q, rq1_d;
    logic [ADDR_W:0] rq2_q, rq2_d;
    logic [ADDR_W:0] wlevel_q, wlevel_d;
    logic [ADDR_W:0] rbin_s;
    logic            wfull_q, wfull_d;
    logic            wafull_q, wafull_d;
    logic            wovf_q, wovf_d;
    logic            push;

    // next-state: accept a write unless full or in reset; flags use the synchronised read pointer
    always_comb begin
        push   = winc & ~wfull_q & wrst_n;
        rbin_s = rq2_q;
        for (int i = ADDR_W - 1; i >= 0; i--) rbin_s[i] = rbin_s[i+1] ^ rq2_q[i];
        wbin_d   = wbin_q + {{ADDR_W{1'b0}}, push};
        wgray_d  = wbin_d ^ (wbin_d >> 1);
        rq1_d    = rptr_gray_async;
        rq2_d    = rq1_q;
        wfull_d  = wgray_d == {~rq2_q[ADDR_W:ADDR_W-1], rq2_q[ADDR_W-2:0]};
        wlevel_d = wbin_d - rbin_s;
        wafull_d = wlevel_d >= AFULL_LV;
        wovf_d   = wovf_q | (winc & wfull_q);
    end

    // state registers with synchronous active-low clear
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            rq1_q    <= '0;
            rq2_q    <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            rq1_q    <= rq1_d;
            rq2_q    <= rq2_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wlevel_q <= wlevel_d;
            wovf_q   <= wovf_d;
        end
    end

    assign wen          = push;
    assign waddr        = wbin_q[ADDR_W-1:0];
    assign wptr_gray    = wgray_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = wovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed checks of the async FIFO write controller
module tb_fifo_wr_ctrl;
    logic       wclk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       winc = 1'b0;
    logic [3:0] rptr_gray_async = 4'b0000;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptr_gray;
    logic       wfull;
    logic       walmost_full;
    logic [3:0] wlevel;
    logic       woverflow;
    int         pass = 0;
    int         total = 0;

    fifo_wr_ctrl #(.ADDR_W(3), .AFULL_TH(6)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rptr_gray_async(rptr_gray_async),
        .wen(wen), .waddr(waddr), .wptr_gray(wptr_gray), .wfull(wfull),
        .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [3:0] g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        wrst_n = 1'b0;
        winc   = 1'b1;
        #1;
        total++; if (wen !== 1'b0) $display("FAIL reset_wen_pre got %b exp 0", wen); else pass++;
        step();
        total++; if (wen !== 1'b0) $display("FAIL reset_wen_mid got %b exp 0", wen); else pass++;
        step();
        total++;
        if ({wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow} !== 15'd0)
            $display("FAIL reset_outputs got wen=%b waddr=%0d gray=%b full=%b af=%b lvl=%0d ovf=%b exp all 0",
                     wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow);
        else pass++;
        winc   = 1'b0;
        wrst_n = 1'b1;
        step();
    endtask

    task automatic test_fill();
        rptr_gray_async = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            winc = 1'b1;
            #0;
            total++; if (wen !== 1'b1) $display("FAIL fill_wen[%0d] got %b exp 1", i, wen); else pass++;
            total++; if (waddr !== 3'(i)) $display("FAIL fill_waddr[%0d] got %0d exp %0d", i, waddr, i); else pass++;
            step();
            total++; if (wlevel !== 4'(i + 1)) $display("FAIL fill_wlevel[%0d] got %0d exp %0d", i, wlevel, i + 1); else pass++;
            total++; if (walmost_full !== (i + 1 >= 6)) $display("FAIL fill_afull[%0d] got %b exp %b", i, walmost_full, i + 1 >= 6); else pass++;
            total++; if (wfull !== (i == 7)) $display("FAIL fill_wfull[%0d] got %b exp %b", i, wfull, i == 7); else pass++;
        end
        total++; if (wptr_gray !== 4'b1100) $display("FAIL fill_gray got %b exp 1100", wptr_gray); else pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            winc = 1'b1;
            #0;
            total++; if (wen !== 1'b0) $display("FAIL ovf_wen[%0d] got %b exp 0", i, wen); else pass++;
            total++; if (waddr !== 3'd0) $display("FAIL ovf_waddr[%0d] got %0d exp 0", i, waddr); else pass++;
            step();
            total++; if (wptr_gray !== 4'b1100) $display("FAIL ovf_gray[%0d] got %b exp 1100", i, wptr_gray); else pass++;
            total++; if (woverflow !== 1'b1) $display("FAIL ovf_flag[%0d] got %b exp 1", i, woverflow); else pass++;
        end
        winc = 1'b0;
        step();
        total++; if (woverflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", woverflow); else pass++;
    endtask

    task automatic test_drain_release();
        rptr_gray_async = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (wfull !== 1'b1) $display("FAIL drain_early_full[%0d] got %b exp 1", i, wfull); else pass++;
            total++; if (wlevel !== 4'd8) $display("FAIL drain_early_lvl[%0d] got %0d exp 8", i, wlevel); else pass++;
        end
        step();
        total++; if (wfull !== 1'b0) $display("FAIL drain_full got %b exp 0", wfull); else pass++;
        total++; if (wlevel !== 4'd7) $display("FAIL drain_lvl got %0d exp 7", wlevel); else pass++;
    endtask

    task automatic test_wrap();
        logic [3:0] wb;
        logic [3:0] nb;
        wb = 4'd8;
        rptr_gray_async = g(4'd6);
        step();
        step();
        for (int j = 0; j < 20; j++) begin
            rptr_gray_async = g(wb - 4'd2);
            winc = 1'b1;
            #0;
            total++; if (wen !== 1'b1) $display("FAIL wrap_wen[%0d] got %b exp 1", j, wen); else pass++;
            total++; if (waddr !== wb[2:0]) $display("FAIL wrap_waddr[%0d] got %0d exp %0d", j, waddr, wb[2:0]); else pass++;
            step();
            nb = wb + 4'd1;
            total++; if (wptr_gray !== g(nb)) $display("FAIL wrap_gray[%0d] got %b exp %b", j, wptr_gray, g(nb)); else pass++;
            if (wb == 4'd15) begin
                total++; if (wptr_gray !== 4'b0000) $display("FAIL wrap_rollover got %b exp 0000", wptr_gray); else pass++;
            end
            total++; if (wlevel !== (j == 0 ? 4'd3 : j == 1 ? 4'd4 : 4'd5))
                $display("FAIL wrap_lvl[%0d] got %0d exp %0d", j, wlevel, j == 0 ? 3 : j == 1 ? 4 : 5); else pass++;
            total++; if (wfull !== 1'b0) $display("FAIL wrap_full[%0d] got %b exp 0", j, wfull); else pass++;
            total++; if (walmost_full !== 1'b0) $display("FAIL wrap_afull[%0d] got %b exp 0", j, walmost_full); else pass++;
            wb = nb;
        end
        winc = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        wrst_n = 1'b0;
        rptr_gray_async = 4'b0000;
        step();
        total++; if (woverflow !== 1'b0) $display("FAIL rmid_ovf_clear got %b exp 0", woverflow); else pass++;
        wrst_n = 1'b1;
        winc   = 1'b1;
        for (int i = 0; i < 5; i++) step();
        total++; if (waddr !== 3'd5) $display("FAIL rmid_pre_waddr got %0d exp 5", waddr); else pass++;
        wrst_n = 1'b0;
        #0;
        total++; if (wen !== 1'b0) $display("FAIL rmid_wen got %b exp 0", wen); else pass++;
        step();
        total++; if (waddr !== 3'd0) $display("FAIL rmid_waddr got %0d exp 0", waddr); else pass++;
        total++; if (wlevel !== 4'd0) $display("FAIL rmid_lvl got %0d exp 0", wlevel); else pass++;
        total++; if (wptr_gray !== 4'b0000) $display("FAIL rmid_gray got %b exp 0000", wptr_gray); else pass++;
        wrst_n = 1'b1;
        #0;
        total++; if (wen !== 1'b1) $display("FAIL rmid_restart_wen got %b exp 1", wen); else pass++;
        step();
        total++; if (wptr_gray !== 4'b0001) $display("FAIL rmid_restart_gray got %b exp 0001", wptr_gray); else pass++;
        total++; if (wlevel !== 4'd1) $display("FAIL rmid_restart_lvl got %0d exp 1", wlevel); else pass++;
        winc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain_release();
        test_wrap();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
